// File: rtl/fp_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_arb_pkg
// Description : Shared definitions for the fp_adder round-robin arbiter.
//               It holds the default floating-point field widths, the derived
//               operand width, the requester-ID width function and the tag
//               record that travels alongside each operation in flight.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fp_arb_pkg;

    localparam int c_e_width = 8;
    localparam int c_m_width = 23;
    localparam int c_w       = c_e_width + c_m_width + 1;

    // Tag IDs are sized for the largest supported requester count (8), so a
    // single tag type serves every configuration. Narrower configurations
    // leave the upper ID bits at zero.
    localparam int c_max_req   = 8;
    localparam int c_tag_id_w  = 3;

    // Requester ID width. It never drops below one bit, so that a
    // two-requester build still has a usable ID field.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [c_tag_id_w-1:0] id;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/fp_adder_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant
// Description : Combinational round-robin priority picker. Searches i_req
//               starting at i_ptr and moving upward modulo N_REQ; the first
//               set request wins.
// Ports       : i_req   - request vector, one bit per requester
//               i_ptr   - index that holds highest priority this cycle
//               o_grant - one-hot grant, all-zero when nothing is requested
//               o_id    - encoded index of the granted requester
//               o_any   - a grant was issued
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_id,
    output logic             o_any
);

    logic [ID_W-1:0] w_idx;

    // Index k positions above p, wrapped back into 0..N_REQ-1. Works for
    // requester counts that are not a power of two.
    function automatic int wrap_idx(input int p, input int k);
        int s;
        s = p + k;
        return (s >= N_REQ) ? (s - N_REQ) : s;
    endfunction

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = ID_W'(wrap_idx(int'(i_ptr), k));
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_id           = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_adder_arbiter
// Description : Shares one pipelined fp_adder among N_REQ requesters. A
//               round-robin grant selects one requester per cycle, its
//               operands are steered to the adder, and a tag pipeline that
//               matches the adder latency carries the requester ID so the sum
//               can be returned on a single tagged response port.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               req_valid/ready   - per-requester handshake
//               req_a/req_b       - packed operands, requester i at [i*W +: W]
//               add_a/add_b       - operands to the fp_adder
//               add_res           - fp_adder result, valid ADD_LAT edges after
//                                   the operands were sampled
//               rsp_valid/id/data - one-cycle tagged response
//               busy              - work in flight or a response presented
//               grant_cnt         - per-requester saturating 16-bit acceptance
//                                   counters (only with FP_ARB_STATS_EN)
// Options     : FP_ARB_STATS_EN   - adds grant_cnt and its counters
// Revision    : 1.0 - initial release
// ============================================================================
module fp_adder_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int E_WIDTH = c_e_width,
    parameter int M_WIDTH = c_m_width,
    parameter int ADD_LAT = 2,
    parameter int ID_W    = id_width(N_REQ)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_REQ-1:0]                       req_valid,
    output logic [N_REQ-1:0]                       req_ready,
    input  logic [N_REQ*(E_WIDTH+M_WIDTH+1)-1:0]   req_a,
    input  logic [N_REQ*(E_WIDTH+M_WIDTH+1)-1:0]   req_b,
    output logic [E_WIDTH+M_WIDTH:0]               add_a,
    output logic [E_WIDTH+M_WIDTH:0]               add_b,
    input  logic [E_WIDTH+M_WIDTH:0]               add_res,
    output logic                                   rsp_valid,
    output logic [ID_W-1:0]                        rsp_id,
    output logic [E_WIDTH+M_WIDTH:0]               rsp_data,
    output logic                                   busy
`ifdef FP_ARB_STATS_EN
   ,output logic [N_REQ*16-1:0]                    grant_cnt
`endif
);

    localparam int c_width = E_WIDTH + M_WIDTH + 1;

    logic [ID_W-1:0]    r_rr_ptr;
    tag_t               r_tag [ADD_LAT];
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [c_width-1:0] r_rsp_data;

    logic [N_REQ-1:0]   w_req_gated;
    logic [N_REQ-1:0]   w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_accept;
    logic               w_busy_any;

    // No grant may be issued while reset is asserted; masking the requests
    // also forces the operand bus to zero for that cycle.
    assign w_req_gated = rst ? '0 : req_valid;

    rr_grant #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_grant (
        .i_req   (w_req_gated),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_id    (w_grant_id),
        .o_any   (w_accept)
    );

    assign req_ready = w_grant;

    // Operand steering; the bus is zero whenever nothing is granted.
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                add_a = req_a[i*c_width +: c_width];
                add_b = req_b[i*c_width +: c_width];
            end
        end
    end

    // Priority moves to the requester just after the one accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;
        end
    end

    // Tag pipeline shadows the adder: stage ADD_LAT-1 is valid exactly in
    // the cycle that add_res carries the matching sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ADD_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0].valid <= w_accept;
            r_tag[0].id    <= c_tag_id_w'(w_grant_id);
            for (int k = 1; k < ADD_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Response register; id/data hold their last value between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= r_tag[ADD_LAT-1].valid;
            if (r_tag[ADD_LAT-1].valid) begin
                r_rsp_id   <= ID_W'(r_tag[ADD_LAT-1].id);
                r_rsp_data <= add_res;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

    always_comb begin
        w_busy_any = r_rsp_valid;
        for (int k = 0; k < ADD_LAT; k++) begin
            w_busy_any = w_busy_any | r_tag[k].valid;
        end
    end

    // Reported idle while reset is held, since everything in flight is
    // about to be discarded.
    assign busy = w_busy_any & ~rst;

`ifdef FP_ARB_STATS_EN
    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_stats
            logic [15:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_grant[i] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign grant_cnt[i*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_adder_arbiter
// Description : Self-checking bench for fp_adder_arbiter. A behavioural
//               fp_adder with ADD_LAT latency is attached; expected responses
//               are queued when requests are issued and a monitor checks them.
// Options     : FP_ARB_STATS_EN - also exercises grant_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_adder_arbiter;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_res;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic           busy;
`ifdef FP_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    fp_adder_arbiter #(
        .N_REQ   (N),
        .E_WIDTH (8),
        .M_WIDTH (23),
        .ADD_LAT (LAT),
        .ID_W    (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_res   (add_res),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef FP_ARB_STATS_EN
       ,.grant_cnt (grant_cnt)
`endif
    );

    // ---------------- single-precision helpers (normal numbers and zero)
    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real x);
        logic s;
        int   e;
        int   m;
        if (x == 0.0) return 32'd0;
        s = (x < 0.0);
        if (s) x = -x;
        e = 127;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0)  begin x = x * 2.0; e--; end
        m = $rtoi((x - 1.0) * 8388608.0);
        return {s, 8'(e), 23'(m)};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rand_fp();
        real v;
        v = real'($urandom_range(1, 4000)) / 4.0;
        if ($urandom_range(0, 1) == 1) v = -v;
        return r2f(v);
    endfunction

    // ---------------- behavioural fp_adder: result ADD_LAT edges later
    logic [W-1:0] adder_pipe [LAT];
    always @(posedge clk) begin
        adder_pipe[0] <= fadd(add_a, add_b);
        for (int k = 1; k < LAT; k++) adder_pipe[k] <= adder_pipe[k-1];
    end
    assign add_res = adder_pipe[LAT-1];

    // ---------------- scoreboard state
    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb [$];
    int          obs_log [$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          model_ptr = 0;
    bit          done = 1'b0;
    logic [31:0] last_rsp2 = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: predict the grant from the round-robin rule, check the
    // handshake and operand bus, queue the expected response, then advance.
    task automatic cycle();
        int           g;
        int           o;
        int           idx;
        logic [N-1:0] oh;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                idx = (model_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(oh));
        chk("add_a", 64'(add_a), (g >= 0) ? 64'(req_a[g*W +: W]) : 64'd0);
        chk("add_b", 64'(add_b), (g >= 0) ? 64'(req_b[g*W +: W]) : 64'd0);
        o = -1;
        for (int k = 0; k < N; k++) if (o < 0 && req_ready[k]) o = k;
        if (o >= 0) obs_log.push_back(o);
        if (g >= 0) begin
            sb.push_back('{id: g, data: fadd(req_a[g*W +: W], req_b[g*W +: W]), due: cyc + LAT + 1});
            model_ptr = (g + 1) % N;
        end
        if (rst) begin
            sb.delete();
            model_ptr = 0;
        end
        @(posedge clk);
        #1;
        if (g >= 0) req_valid[g] = 1'b0;
    endtask

    // ---------------- monitor
    always @(negedge clk) begin
        exp_t e;
        bit   bexp;
        if (!done) begin
            bexp = 1'b0;
            if (!rst) begin
                foreach (sb[k]) if (cyc >= sb[k].due - LAT && cyc <= sb[k].due) bexp = 1'b1;
            end
            chk("busy", 64'(busy), 64'(bexp));
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                    chk("rsp_cycle", 64'(cyc), 64'(e.due));
                    if (e.id == 2) last_rsp2 = rsp_data;
                end
            end else if (!rst && sb.size() > 0 && sb[0].due <= cyc) begin
                chk("rsp_missing", 64'd0, 64'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus
    initial begin
        int          exp_order [$];
        logic [31:0] held;

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        cycle();
        cycle();
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // Single request: 1.0 + 2.0
        req_a[0 +: W] = 32'h3F800000;
        req_b[0 +: W] = 32'h40000000;
        req_valid[0]  = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("single_rsp_id", 64'(rsp_id), 64'd0);
        chk("single_rsp_data", 64'(rsp_data), 64'h40400000);
        cycle();
        chk("single_rsp_drop", 64'(rsp_valid), 64'd0);
        chk("single_busy_fall", 64'(busy), 64'd0);

        // Full contention from pointer 0
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = r2f(real'(i + 1));
            req_b[i*W +: W] = r2f(real'(2 * i + 3));
        end
        req_a[2*W +: W] = 32'h3FC00000;
        req_b[2*W +: W] = 32'h40200000;
        obs_log.delete();
        repeat (5) begin
            req_valid = '1;
            cycle();
        end
        req_valid = '0;
        repeat (LAT + 2) cycle();
        exp_order = '{0, 1, 2, 3, 0};
        chk("contention_count", 64'(obs_log.size()), 64'd5);
        for (int k = 0; k < 5 && k < obs_log.size(); k++) chk("contention_grant", 64'(obs_log[k]), 64'(exp_order[k]));
        chk("contention_req2_sum", 64'(last_rsp2), 64'h40800000);

        // Wrap-around: grant 2, then 3 and 0 compete, then 0 and 1
        obs_log.delete();
        req_valid = 4'b0100;
        cycle();
        req_valid = 4'b1001;
        cycle();
        cycle();
        req_valid = 4'b0011;
        cycle();
        req_valid = '0;
        repeat (LAT + 2) cycle();
        exp_order = '{2, 3, 0, 1};
        chk("wrap_count", 64'(obs_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < obs_log.size(); k++) chk("wrap_grant", 64'(obs_log[k]), 64'(exp_order[k]));

        // Reset with two operations in flight
        req_valid[0] = 1'b1;
        cycle();
        req_valid[1] = 1'b1;
        cycle();
        req_valid[2] = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        cycle();
        rst = 1'b0;
        repeat (LAT + 4) cycle();

        // Idle: operand bus zero, response data held
        req_valid = '0;
        held = rsp_data;
        repeat (5) begin
            cycle();
            chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("idle_rsp_hold", 64'(rsp_data), 64'(held));
        end
        req_valid = '1;
        cycle();
        req_valid = '0;
        repeat (LAT + 2) cycle();

        // Randomized traffic
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_a[i*W +: W] = rand_fp();
                    req_b[i*W +: W] = rand_fp();
                    req_valid[i]    = 1'b1;
                end
            end
            cycle();
        end
        req_valid = '0;
        repeat (LAT + 3) cycle();
        chk("drain_empty", 64'(sb.size()), 64'd0);

`ifdef FP_ARB_STATS_EN
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("stats_clear", 64'(grant_cnt), 64'd0);
        repeat (3) begin
            req_valid = 4'b0010;
            cycle();
        end
        req_valid = '0;
        chk("stats_req1", 64'(grant_cnt[31:16]), 64'd3);
        chk("stats_req0", 64'(grant_cnt[15:0]), 64'd0);
        repeat (LAT + 2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("stats_after_rst", 64'(grant_cnt[31:16]), 64'd0);
`endif

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_adder_arbiter.md
Name: fp_adder_arbiter

Overview:
- Shares one pipelined fp_adder between N_REQ requesters using round-robin arbitration with a per-requester valid/ready handshake.
- Drives the adder operands and tracks requester IDs through the adder's fixed latency.
- Returns each sum on a single response port tagged with the originating requester ID.
- Sits between the requesting compute units and the single fp_adder instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- E_WIDTH, 8, exponent width.
- M_WIDTH, 23, mantissa width. Operand width W = E_WIDTH+M_WIDTH+1.
- ADD_LAT, 2, clock edges from the fp_adder sampling A/B to res being valid (>=1).
- ID_W, $clog2(N_REQ), requester ID width.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, N_REQ, request present per requester.
- req_ready, output, N_REQ, grant per requester; one-hot or zero.
- req_a, input, N_REQ*W, operand A; requester i occupies bits [i*W +: W].
- req_b, input, N_REQ*W, operand B, same packing as req_a.
- add_a, output, W, to fp_adder A.
- add_b, output, W, to fp_adder B.
- add_res, input, W, from fp_adder res.
- rsp_valid, output, 1, response strobe (one cycle).
- rsp_id, output, ID_W, requester that issued the response.
- rsp_data, output, W, sum.
- busy, output, 1, high while any operation is in flight or rsp_valid is high.

Behaviour:
- Reset (rst high at a rising edge):
  - rr_ptr=0.
  - Tag pipeline valid bits cleared.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req_ready=0 during the cycle rst is high.
- Reset mid-operation: all in-flight operations are discarded and never produce rsp_valid, even if add_res later settles.
- Arbitration is combinational:
  - Grant the first i with req_valid[i]=1, searching from rr_ptr upward modulo N_REQ.
  - req_ready[i]=1 only for the granted requester.
  - At most one acceptance per cycle.
- Handshake:
  - Transfer occurs when req_valid[i]&req_ready[i] at a rising edge.
  - A requester holds req_valid and its operands stable until accepted.
  - A requester may not drop req_valid before acceptance.
- Pointer update:
  - On acceptance of i, rr_ptr <= (i+1) mod N_REQ, wrapping from N_REQ-1 to 0.
  - With no acceptance, rr_ptr holds.
- Operand drive:
  - add_a/add_b = granted requester's req_a/req_b, combinationally.
  - Both are all-zero when there is no grant.
- Tag pipeline:
  - ADD_LAT-deep shift register of {valid, id}, advancing every cycle.
  - Stage 0 loads {accepted, grant_id}.
- Response timing:
  - When the last stage is valid, register rsp_valid=1, rsp_id=tag id, rsp_data=add_res.
  - An acceptance in cycle c gives rsp_valid high in cycle c+ADD_LAT+1 for exactly one cycle.
  - Otherwise rsp_valid=0 and rsp_id/rsp_data hold their last value.
- Throughput: one result per cycle, in issue order. There is no response backpressure; consumers must accept every response.
- busy: OR of all tag valid bits and rsp_valid.
- Simultaneous events: a new acceptance and a retiring response in the same cycle are both serviced.
- Single active requester: it is granted every cycle.
- All requesters active: grant order is rr_ptr, rr_ptr+1, and so on, so no requester waits more than N_REQ-1 cycles.

Optional Feature:
- Macro: FP_ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt, N_REQ*16 bits.
  - One saturating 16-bit counter per requester, incremented on each acceptance for that requester.
  - Counters hold at 16'hFFFF when saturated.
  - Counters clear on rst.
- When undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package fp_arb_pkg holds:
  - E_WIDTH/M_WIDTH defaults and the derived W.
  - ID width function.
  - Typedef tag_t {logic valid; logic [ID_W-1:0] id}.
- One sub-module, rr_grant: combinational round-robin priority picker taking req and ptr and producing a one-hot grant plus an encoded id.

Test Plan:
- Single request:
  - Stimulus: after rst, requester 0 sends A=0x3F800000 (1.0), B=0x40000000 (2.0).
  - Response: req_ready[0] high the same cycle; rsp_valid exactly ADD_LAT+1 cycles later with rsp_id=0, rsp_data=0x40400000 (3.0); busy falls the cycle after.
- Full contention:
  - Stimulus: all 4 requesters valid continuously, rr_ptr=0.
  - Response: grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence 0,1,2,3 back-to-back; requester 2 (A=0x3FC00000, B=0x40200000) returns 0x40800000.
- Wrap-around:
  - Stimulus: only requesters 3 and 0 valid after a grant to 2.
  - Response: grant 3, then 0; rr_ptr wraps to 0, then 1.
- Reset mid-flight:
  - Stimulus: issue 2 requests, then assert rst for 1 cycle before either retires.
  - Response: no rsp_valid for them; busy=0 and req_ready=0 during rst; a new request after rst completes normally.
- Idle and hold:
  - Stimulus: no req_valid for 5 cycles.
  - Response: add_a=add_b=0, rr_ptr unchanged, rsp_valid=0, rsp_data holding its last value.
- Stats (FP_ARB_STATS_EN):
  - Stimulus: 3 grants to requester 1, then rst.
  - Response: grant_cnt[31:16]=3, then 0 after rst.
